code_word_decoder: RTL and testbench

Receive-side counterpart of the literal code-word generator: accepts 8-bit header/payload words and 6-bit status codes, validates them against the same constants, and recovers the original A1/A2/B1/B2 control flags. A confirmation state machine commits a decode only after CONFIRM consecutive identical words. Bad words are counted and flagged. Sits between the code-word link and the control logic that consumes the flags.

---
 rtl/code_word_pkg.sv | 29 ++
 rtl/code_word_decoder_word_classify.sv | 38 +++
 rtl/code_word_decoder.sv | 144 ++++++++++++++
 tb/tb_code_word_decoder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/code_word_pkg.sv
// Shared constants, state encoding and flag bundle for the code-word decoder.
package code_word_pkg;

    localparam logic [3:0] CST_DEF = 4'b1010;
    localparam logic [3:0] PL_A1   = 4'b0000;
    localparam logic [3:0] PL_A2   = 4'b0101;
    localparam logic [5:0] ST_00   = 6'd10;
    localparam logic [5:0] ST_11   = 6'd15;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONFIRM,
        S_LOCKED,
        S_ERRHOLD
    } state_t;

    typedef struct packed {
        logic a1;
        logic a2;
        logic b1;
        logic b2;
    } flags_t;

    // Third status code: TF + 10 + 15, wrapped to 6 bits.
    function automatic logic [5:0] status_b1(input int tf);
        return 6'((tf + 25) % 64);
    endfunction

endpackage

// File: rtl/code_word_decoder_word_classify.sv
// Combinational check of one {header,payload}/status word and flag decode.
module word_classify
    import code_word_pkg::*;
#(
    parameter logic [3:0] CST = CST_DEF,
    parameter int         TF  = 25
) (
    input  logic [7:0] y1,
    input  logic [5:0] y2,
    output logic       valid,
    output flags_t     flags
);

    localparam logic [5:0] ST_10 = status_b1(TF);

    if (ST_10 == ST_00 || ST_10 == ST_11) begin : g_bad_tf
        $error("word_classify: TF makes the third status code collide");
    end

    logic hdr_ok;
    logic pa1;
    logic pa2;
    logic s00;
    logic s11;
    logic s10;

    always_comb begin
        hdr_ok = (y1[7:4] == CST);
        pa1    = (y1[3:0] == PL_A1);
        pa2    = (y1[3:0] == PL_A2);
        s00    = (y2 == ST_00);
        s11    = (y2 == ST_11);
        s10    = (y2 == ST_10);
        valid  = hdr_ok && (pa1 || pa2) && (s00 || s11 || s10);
        flags  = '{a1: pa1, a2: pa2, b1: s11 || s10, b2: s11};
    end

endmodule

// File: rtl/code_word_decoder.sv
// Code-word receiver: validates words, confirms repeats, commits flags,
// and counts rejected words.
module code_word_decoder
    import code_word_pkg::*;
#(
    parameter logic [3:0] CST     = CST_DEF,
    parameter int         TF      = 25,
    parameter int         CONFIRM = 2,
    parameter int         ERRW    = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            VALID,
    input  logic [7:0]      Y1,
    input  logic [5:0]      Y2,
    output logic            READY,
    output logic            A1,
    output logic            A2,
    output logic            B1,
    output logic            B2,
    output logic            LOCK,
    output logic            ERR,
    output logic [ERRW-1:0] ERR_CNT
);

    if (CONFIRM < 1 || CONFIRM > 15) begin : g_bad_confirm
        $error("code_word_decoder: CONFIRM must be 1..15");
    end

    localparam logic [3:0] CONF4 = 4'(CONFIRM);

    state_t          state_q, state_d;
    logic [13:0]     cand_q, cand_d;
    logic [3:0]      cnt_q, cnt_d;
    flags_t          flags_q, flags_d;
    logic [ERRW-1:0] ecnt_q, ecnt_d;
    logic            ready_q, ready_d;
    logic            lock_q, lock_d;
    logic            err_q, err_d;

    logic        w_valid;
    flags_t      w_flags;
    logic [13:0] word;
    logic        xfer;
    logic        match;
    logic        start;

    word_classify #(.CST(CST), .TF(TF)) u_cls (
        .y1    (Y1),
        .y2    (Y2),
        .valid (w_valid),
        .flags (w_flags)
    );

    assign word  = {Y1, Y2};
    assign xfer  = VALID && ready_q;
    assign match = (word == cand_q);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            flags_q <= '0;
            ecnt_q  <= '0;
            ready_q <= 1'b0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
            ecnt_q  <= ecnt_d;
            ready_q <= ready_d;
            lock_q  <= lock_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        flags_d = flags_q;
        ecnt_d  = ecnt_q;
        err_d   = 1'b0;
        start   = 1'b0;

        if (state_q == S_ERRHOLD) begin
            state_d = S_IDLE;
        end else if (xfer && !w_valid) begin
            state_d = S_ERRHOLD;
            cand_d  = '0;
            cnt_d   = '0;
            err_d   = 1'b1;
            if (ecnt_q != '1) begin
                ecnt_d = ecnt_q + 1'b1;
            end
        end else if (xfer) begin
            unique case (state_q)
                S_IDLE: start = 1'b1;
                S_CONFIRM: begin
                    if (match) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == CONF4) begin
                            state_d = S_LOCKED;
                            flags_d = w_flags;
                        end
                    end else begin
                        start = 1'b1;
                    end
                end
                S_LOCKED: start = !match;
                default: ;
            endcase
        end

        // A fresh candidate; with CONFIRM==1 it commits on the spot.
        if (start) begin
            cand_d = word;
            cnt_d  = 4'd1;
            if (CONFIRM == 1) begin
                state_d = S_LOCKED;
                flags_d = w_flags;
            end else begin
                state_d = S_CONFIRM;
            end
        end

        ready_d = (state_d != S_ERRHOLD);
        lock_d  = (state_d == S_LOCKED);
    end

    assign READY   = ready_q;
    assign A1      = flags_q.a1;
    assign A2      = flags_q.a2;
    assign B1      = flags_q.b1;
    assign B2      = flags_q.b2;
    assign LOCK    = lock_q;
    assign ERR     = err_q;
    assign ERR_CNT = ecnt_q;

endmodule

// File: tb/tb_code_word_decoder.sv
// Bench for code_word_decoder: run-length reference model checked every
// cycle, plus directed literal expectations.
module tb_code_word_decoder;

    localparam int CONFIRM = 2;
    localparam int ERRW    = 2;
    localparam int TF      = 25;
    localparam int EMAX    = (1 << ERRW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            valid = 1'b0;
    logic [7:0]      y1 = '0;
    logic [5:0]      y2 = '0;
    logic            ready, a1, a2, b1, b2, lock, err;
    logic [ERRW-1:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    code_word_decoder #(
        .CST     (4'b1010),
        .TF      (TF),
        .CONFIRM (CONFIRM),
        .ERRW    (ERRW)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .VALID   (valid),
        .Y1      (y1),
        .Y2      (y2),
        .READY   (ready),
        .A1      (a1),
        .A2      (a2),
        .B1      (b1),
        .B2      (b2),
        .LOCK    (lock),
        .ERR     (err),
        .ERR_CNT (err_cnt)
    );

    bit        m_init = 1'b0;
    bit        m_ready, m_err, m_lock, m_x;
    bit [3:0]  m_flags;
    int        m_errcnt;
    int        run_len;
    bit [13:0] run_word;

    function automatic bit is_good(input bit [7:0] a, input bit [5:0] b);
        int p, h, s;
        h = a / 16;
        p = a % 16;
        s = b;
        return h == 10 && (p == 0 || p == 5) &&
               (s == 10 || s == 15 || s == (TF + 25) % 64);
    endfunction

    // A commit happens when a run of identical valid words reaches CONFIRM.
    always @(posedge clk) begin
        if (rst) begin
            m_init   = 1'b1;
            m_ready  = 1'b0;
            m_err    = 1'b0;
            m_lock   = 1'b0;
            m_flags  = '0;
            m_errcnt = 0;
            run_len  = 0;
        end else begin
            m_x   = valid && m_ready;
            m_err = 1'b0;
            if (m_x) begin
                if (!is_good(y1, y2)) begin
                    m_err   = 1'b1;
                    run_len = 0;
                    if (m_errcnt < EMAX) m_errcnt++;
                end else begin
                    if (run_len > 0 && {y1, y2} == run_word) begin
                        if (run_len < 100) run_len++;
                    end else begin
                        run_word = {y1, y2};
                        run_len  = 1;
                    end
                    if (run_len == CONFIRM)
                        m_flags = {y1 % 16 == 0, y1 % 16 == 5,
                                   y2 != 10, y2 == 15};
                end
            end
            m_lock  = run_len >= CONFIRM;
            m_ready = !m_err;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            n_cmp++;
            if ({ready, a1, a2, b1, b2, lock, err, err_cnt} !==
                {m_ready, m_flags, m_lock, m_err, ERRW'(m_errcnt)}) begin
                n_bad++;
                $display("FAIL model t=%0t dut rdy/flags/lock/err/cnt=%b/%b/%b/%b/%0d required %b/%b/%b/%b/%0d",
                         $time, ready, {a1, a2, b1, b2}, lock, err, err_cnt,
                         m_ready, m_flags, m_lock, m_err, m_errcnt);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input bit v, input logic [7:0] a,
                        input logic [5:0] b);
        valid = v;
        y1    = a;
        y2    = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [7:0] bad_y1 [5] = '{8'hA1, 8'hA0, 8'h50, 8'hAF, 8'hA5};
    logic [5:0] bad_y2 [5] = '{6'd10, 6'd11, 6'd15, 6'd15, 6'd49};

    initial begin
        repeat (2) @(negedge clk);
        chk("ready_in_reset", 8'(ready), 8'd0);
        chk("lock_reset", 8'(lock), 8'd0);
        chk("errcnt_reset", 8'(err_cnt), 8'd0);
        rst = 1'b0;
        step(0, 8'h00, 6'd0);
        chk("ready_after_reset", 8'(ready), 8'd1);

        step(1, 8'hA0, 6'd10);
        chk("t1_lock_first", 8'(lock), 8'd0);
        step(1, 8'hA0, 6'd10);
        chk("t1_lock", 8'(lock), 8'd1);
        chk("t1_flags", 8'({a1, a2, b1, b2}), 8'b1000);

        step(1, 8'hA5, 6'd50);
        chk("t2_lock_drop", 8'(lock), 8'd0);
        chk("t2_flags_hold", 8'({a1, a2, b1, b2}), 8'b1000);
        step(1, 8'hA5, 6'd50);
        chk("t2_lock", 8'(lock), 8'd1);
        chk("t2_flags", 8'({a1, a2, b1, b2}), 8'b0110);

        step(1, 8'hB0, 6'd10);
        chk("t3_err", 8'(err), 8'd1);
        chk("t3_ready", 8'(ready), 8'd0);
        chk("t3_errcnt", 8'(err_cnt), 8'd1);
        chk("t3_flags", 8'({a1, a2, b1, b2}), 8'b0110);
        chk("t3_lock", 8'(lock), 8'd0);
        step(0, 8'h00, 6'd0);
        chk("t3_err_one_cycle", 8'(err), 8'd0);
        chk("t3_ready_back", 8'(ready), 8'd1);

        for (int i = 0; i < 6; i++) begin
            step(1, (i % 2 == 0) ? 8'hA0 : 8'hA5, 6'd15);
            chk("t4_no_lock", 8'({lock, err}), 8'd0);
        end
        chk("t4_flags_hold", 8'({a1, a2, b1, b2}), 8'b0110);

        for (int i = 0; i < 5; i++) begin
            step(1, bad_y1[i], bad_y2[i]);
            chk("t5_err", 8'(err), 8'd1);
            step(1, bad_y1[i], bad_y2[i]);
            chk("t5_hold_not_taken", 8'(err), 8'd0);
        end
        chk("t5_errcnt_sat", 8'(err_cnt), 8'd3);
        chk("t5_flags_hold", 8'({a1, a2, b1, b2}), 8'b0110);

        step(1, 8'hA0, 6'd10);
        rst = 1'b1;
        step(1, 8'hA0, 6'd10);
        rst = 1'b0;
        chk("t6_outputs_cleared",
            8'({ready, a1, a2, b1, b2, lock, err, err_cnt != 0}), 8'd0);
        step(1, 8'hA0, 6'd10);
        chk("t6_ready", 8'(ready), 8'd1);
        step(1, 8'hA0, 6'd10);
        chk("t6_no_stale_commit", 8'(lock), 8'd0);
        step(1, 8'hA0, 6'd10);
        chk("t6_lock", 8'(lock), 8'd1);
        chk("t6_flags", 8'({a1, a2, b1, b2}), 8'b1000);
        step(0, 8'h00, 6'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
